// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - N-way write-back/write-allocate cache control FSM with tree PLRU victim choice
// Optional CACHE_CTRL_PERF_EN adds wrapping 32-bit hit_count/miss_count outputs.
module cache_control_nway #(
  parameter int WAYS   = 4,
  parameter int PLRU_W = WAYS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cyc,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  output logic              cpu_ack,
  input  logic [WAYS-1:0]   hit_way,
  input  logic [WAYS-1:0]   valid,
  input  logic [WAYS-1:0]   dirty,
  input  logic [PLRU_W-1:0] plru_out,
  output logic              plru_write,
  output logic [PLRU_W-1:0] plru_in,
  output logic [WAYS-1:0]   way_write,
  output logic [WAYS-1:0]   valid_write,
  output logic [WAYS-1:0]   valid_in,
  output logic [WAYS-1:0]   dirty_write,
  output logic [WAYS-1:0]   dirty_in,
  output logic [WAYS-1:0]   victim_way,
  output logic              datainmux_sel,
  output logic              memaddrmux_sel,
  input  logic              mem_ack,
  input  logic              mem_rty,
  output logic              mem_cyc,
  output logic              mem_stb,
  output logic              mem_we
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int LOG = $clog2(WAYS);
  typedef logic [LOG-1:0]  idx_t;
  typedef logic [WAYS-1:0] vec_t;
  typedef enum logic [2:0] {IDLE, WRITE_BACK, WB_GAP, ALLOCATE, RETRY} state_t;

  state_t state, state_next, ret, ret_next;
  vec_t   victim_next, miss_pick;
  logic   req, hit;

  // Walk from the root: a set bit steers to the upper half (child 2n+1), a clear bit to the lower (2n+2).
  function automatic idx_t plru_pick(input logic [PLRU_W-1:0] p);
    vec_t pe;
    idx_t node, idx;
    logic b;
    pe = vec_t'(p);
    node = '0;
    idx = '0;
    for (int l = 0; l < LOG; l++) begin
      b = pe[node];
      idx = idx_t'({idx, b});
      node = idx_t'(2 * int'(node) + (b ? 1 : 2));
    end
    return idx;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p, input idx_t w);
    vec_t pe;
    idx_t node, wi;
    logic b;
    pe = vec_t'(p);
    node = '0;
    wi = w;
    for (int l = 0; l < LOG; l++) begin
      b = wi[LOG-1];
      pe[node] = ~b;
      wi = wi << 1;
      node = idx_t'(2 * int'(node) + (b ? 1 : 2));
    end
    return pe[PLRU_W-1:0];
  endfunction

  function automatic idx_t onehot_idx(input vec_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < WAYS; i++)
      if (v[i]) r = idx_t'(i);
    return r;
  endfunction

  assign req = cpu_cyc & cpu_stb;
  assign hit = |hit_way;

  // Invalid ways are filled lowest-index first; PLRU only chooses among a full set.
  always_comb begin
    miss_pick = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid[i]) miss_pick = vec_t'(1) << i;
    if (&valid) miss_pick = vec_t'(1) << plru_pick(plru_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ret        <= ALLOCATE;
      victim_way <= '0;
    end else begin
      state      <= state_next;
      ret        <= ret_next;
      victim_way <= victim_next;
    end
  end

  always_comb begin
    state_next     = state;
    ret_next       = ret;
    victim_next    = victim_way;
    cpu_ack        = 1'b0;
    plru_write     = 1'b0;
    plru_in        = '0;
    way_write      = '0;
    valid_write    = '0;
    valid_in       = '0;
    dirty_write    = '0;
    dirty_in       = '0;
    datainmux_sel  = 1'b0;
    memaddrmux_sel = 1'b0;
    mem_cyc        = 1'b0;
    mem_stb        = 1'b0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_ack    = 1'b1;
            plru_write = 1'b1;
            plru_in    = plru_touch(plru_out, onehot_idx(hit_way));
            if (cpu_we) begin
              datainmux_sel = 1'b1;
              way_write     = hit_way;
              valid_write   = hit_way;
              valid_in      = hit_way;
              dirty_write   = hit_way;
              dirty_in      = hit_way;
            end
          end else begin
            victim_next = miss_pick;
            state_next  = |(miss_pick & valid & dirty) ? WRITE_BACK : ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        mem_cyc        = 1'b1;
        mem_stb        = 1'b1;
        mem_we         = 1'b1;
        memaddrmux_sel = 1'b1;
        if (mem_ack) begin
          state_next = WB_GAP;
        end else if (mem_rty) begin
          state_next = RETRY;
          ret_next   = WRITE_BACK;
        end
      end
      WB_GAP: state_next = ALLOCATE;
      ALLOCATE: begin
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        if (mem_ack) begin
          way_write   = victim_way;
          valid_write = victim_way;
          valid_in    = victim_way;
          dirty_write = victim_way;
          state_next  = IDLE;
        end else if (mem_rty) begin
          state_next = RETRY;
          ret_next   = ALLOCATE;
        end
      end
      RETRY: state_next = ret;
      default: state_next = IDLE;
    endcase
    // A reset cycle must not commit anything into the arrays or acknowledge the CPU.
    if (rst) begin
      cpu_ack     = 1'b0;
      plru_write  = 1'b0;
      way_write   = '0;
      valid_write = '0;
      dirty_write = '0;
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && cpu_ack) hit_count <= hit_count + 32'd1;
      if (state == IDLE && (state_next == WRITE_BACK || state_next == ALLOCATE))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
